// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM arbiter: default geometry, the default
// reserved-phase mask, the CPU access FSM state type and the video-slot test.
package vram_pkg;

  localparam int unsigned ADDR_W_DEF   = 13;
  localparam int unsigned DATA_W_DEF   = 8;
  localparam logic [7:0]  RSV_MASK_DEF = 8'b0000_1010;

  typedef enum logic [1:0] {
    CPU_IDLE  = 2'd0,
    CPU_WAIT  = 2'd1,
    CPU_RDATA = 2'd2
  } cpu_state_e;

  // A phase belongs to the video fetcher only during active display.
  function automatic logic is_video_slot(input logic [7:0] mask,
                                         input logic [2:0] phase,
                                         input logic       hblank,
                                         input logic       vblank);
    return ~(hblank | vblank) & mask[phase];
  endfunction

endpackage

// File: rtl/vram_fill.sv
// Screen-fill engine: writes a constant value over a run of addresses,
// one word per slot the arbiter hands it, wrapping at the top of the RAM.
module vram_fill
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W:0]   i_len,
  input  logic [DATA_W-1:0] i_value,
  input  logic              i_grant,
  output logic              o_wr,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_value,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'(1);

  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_value;
  logic              w_wr;

  // A write happens only in a slot neither video nor the CPU is using.
  assign w_wr    = r_busy & i_grant;
  assign o_wr    = w_wr;
  assign o_addr  = r_addr;
  assign o_value = r_value;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

  // Command capture, address/count stepping and the one-cycle done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: every register is reset so an interrupted fill can never resume.
    if (!reset_n) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_addr  <= '0;
      r_count <= '0;
      r_value <= '0;
    end else begin
      // NOTE: non-blocking assignments, so each register sees pre-edge values.
      r_done <= 1'b0;
      if (w_wr) begin
        r_addr  <= r_addr + 1'b1;
        r_count <= r_count - 1'b1;
        if (r_count == LAST_WORD) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end else if (!r_busy && i_start) begin
        r_addr  <= i_base;
        r_count <= i_len;
        r_value <= i_value;
        if (i_len == '0) r_done <= 1'b1;
        else             r_busy <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: video fetch > CPU access > screen fill.
// Optional feature: define VRAM_ARB_STALL_CNT_EN to add the stall_cnt output,
// a saturating count of CPU cycles spent waiting behind video slots.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter logic [7:0]  RSV_MASK = RSV_MASK_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        phase,
  input  logic              hblank,
  input  logic              vblank,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [ADDR_W:0]   fill_len,
  input  logic [DATA_W-1:0] fill_value,
  output logic              fill_busy,
  output logic              fill_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef VRAM_ARB_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  cpu_state_e        r_state;
  cpu_state_e        w_state_nxt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  logic              w_video;
  logic              w_cpu_grant;
  logic              w_cpu_ack;
  logic              w_slot_free;
  logic              w_fill_wr;
  logic [ADDR_W-1:0] w_fill_addr;
  logic [DATA_W-1:0] w_fill_value;

  assign w_video = is_video_slot(RSV_MASK, phase, hblank, vblank);

  // CPU FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= CPU_IDLE;
    else          r_state <= w_state_nxt;
  end

  // CPU FSM next state: wait out video slots, then one cycle for read data.
  always_comb begin
    // NOTE: default first so no path through the case leaves a latch.
    w_state_nxt = r_state;
    case (r_state)
      CPU_IDLE:  if (cpu_req)  w_state_nxt = CPU_WAIT;
      CPU_WAIT:  if (!w_video) w_state_nxt = CPU_RDATA;
      CPU_RDATA: w_state_nxt = CPU_IDLE;
      default:   w_state_nxt = CPU_IDLE;
    endcase
  end

  // CPU FSM outputs: RAM grant while waiting in a free slot, ack in RDATA.
  always_comb begin
    w_cpu_grant = 1'b0;
    w_cpu_ack   = 1'b0;
    case (r_state)
      CPU_WAIT:  w_cpu_grant = ~w_video;
      CPU_RDATA: w_cpu_ack   = 1'b1;
      default:   ;
    endcase
  end

  // Request latch on acceptance and read-data capture at completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (r_state == CPU_IDLE && cpu_req) begin
        r_we    <= cpu_we;
        r_addr  <= cpu_addr;
        r_wdata <= cpu_wdata;
      end
      if (r_state == CPU_RDATA && !r_we) r_rdata <= ram_rdata;
    end
  end

  // Read data is forwarded in the ack cycle and held afterwards.
  assign cpu_ack   = w_cpu_ack;
  assign cpu_rdata = (w_cpu_ack && !r_we) ? ram_rdata : r_rdata;

  assign w_slot_free = ~w_video & ~w_cpu_grant;

  vram_fill #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fill (
    .clk     (clk),
    .reset_n (reset_n),
    .i_start (fill_start),
    .i_base  (fill_base),
    .i_len   (fill_len),
    .i_value (fill_value),
    .i_grant (w_slot_free),
    .o_wr    (w_fill_wr),
    .o_addr  (w_fill_addr),
    .o_value (w_fill_value),
    .o_busy  (fill_busy),
    .o_done  (fill_done)
  );

  // RAM port mux: video (or idle) address by default, then CPU, then fill.
  always_comb begin
    ram_addr  = vid_addr;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (w_cpu_grant) begin
      ram_addr  = r_addr;
      ram_we    = r_we;
      ram_wdata = r_we ? r_wdata : '0;
    end else if (w_fill_wr) begin
      ram_addr  = w_fill_addr;
      ram_we    = 1'b1;
      ram_wdata = w_fill_value;
    end
  end

`ifdef VRAM_ARB_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Count WAIT cycles lost to video slots, holding at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if (r_state == CPU_WAIT && !w_cpu_grant && r_stall_cnt != 16'hFFFF) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
